// File: rtl/tick_sequencer_pkg.sv
// Shared types and constants for the tick sequencer: one-hot FSM state
// encoding and the one-shot/periodic mode values.
package tick_seq_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'b001,
    RUN  = 3'b010,
    FIRE = 3'b100
  } state_t;

  localparam logic MODE_ONESHOT  = 1'b0;
  localparam logic MODE_PERIODIC = 1'b1;

endpackage

// File: rtl/tick_sequencer_if.sv
// Control/status bundle between a sequenced FSM (master) and the tick
// sequencer (slave).
interface tick_sequencer_if #(
  parameter int CW = 16
);

  logic          en;
  logic          start;
  logic          stop;
  logic          mode;
  logic [CW-1:0] period;
  logic          rdy;
  logic          busy;
  logic [CW-1:0] count;
  logic          overrun;

  modport master (
    output en, start, stop, mode, period,
    input  rdy, busy, count, overrun
  );

  modport slave (
    input  en, start, stop, mode, period,
    output rdy, busy, count, overrun
  );

endinterface

// File: rtl/tick_sequencer_prescaler.sv
// Modulo-PRESCALE clock divider; tick marks the last enabled cycle of each
// prescale period so the next edge both wraps the divider and advances the count.
module tick_prescaler #(
  parameter int PRESCALE = 50
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic tick
);

  localparam int PW = $clog2(PRESCALE);
  localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

  logic [PW-1:0] r_cnt;

  assign tick = en && (r_cnt == LAST);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt <= '0;
    end else if (clr) begin
      r_cnt <= '0;
    end else if (en) begin
      r_cnt <= tick ? '0 : r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/tick_sequencer.sv
// Programmable interval timer producing the single-cycle rdy strobe that
// paces the sequenced FSMs; one-shot or periodic, restartable and abortable.
module tick_sequencer
  import tick_seq_pkg::*;
#(
  parameter int CW       = 16,
  parameter int PRESCALE = 50
) (
  input logic             clk,
  input logic             reset,
  tick_sequencer_if.slave bus
);

  state_t        r_state;
  logic [CW-1:0] r_count;
  logic [CW-1:0] r_reload;
  logic          r_mode;
  logic          r_overrun;

  logic w_tick;
  logic w_accept;
  logic w_prescEn;
  logic w_prescClr;

  // A zero period never starts anything, and stop outranks a simultaneous start.
  assign w_accept   = bus.start && (bus.period != '0) && !bus.stop;
  assign w_prescEn  = bus.en && (r_state != IDLE);
  assign w_prescClr = (r_state == IDLE) || bus.stop || w_accept;

  tick_prescaler #(
    .PRESCALE (PRESCALE)
  ) u_prescaler (
    .clk   (clk),
    .reset (reset),
    .clr   (w_prescClr),
    .en    (w_prescEn),
    .tick  (w_tick)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= IDLE;
      r_count   <= '0;
      r_reload  <= '0;
      r_mode    <= MODE_ONESHOT;
      r_overrun <= 1'b0;
    end else begin
      r_overrun <= 1'b0;
      if (bus.stop) begin
        r_state <= IDLE;
        r_count <= '0;
      end else if (w_accept) begin
        r_state   <= RUN;
        r_count   <= bus.period;
        r_reload  <= bus.period;
        r_mode    <= bus.mode;
        r_overrun <= (r_state != IDLE);
      end else begin
        case (r_state)
          IDLE: r_state <= IDLE;
          RUN: begin
            if (w_tick && (r_count != '0)) begin
              r_count <= r_count - 1'b1;
              if (r_count == CW'(1)) r_state <= FIRE;
            end
          end
          // FIRE lasts one cycle; the prescaler keeps running so periodic
          // strobes stay exactly period*PRESCALE apart.
          FIRE: begin
            if (r_mode == MODE_PERIODIC) begin
              r_count <= r_reload;
              r_state <= RUN;
            end else begin
              r_state <= IDLE;
            end
          end
          default: begin
            r_state <= IDLE;
            r_count <= '0;
          end
        endcase
      end
    end
  end

  assign bus.rdy     = (r_state == FIRE);
  assign bus.busy    = (r_state != IDLE);
  assign bus.count   = r_count;
  assign bus.overrun = r_overrun;

endmodule

// File: tb/tb_tick_sequencer.sv
// Bench for tick_sequencer: directed scenarios with hand-computed strobes plus
// randomized traffic compared every cycle against an elapsed-time model.
module tb_tick_sequencer;
  import tick_seq_pkg::*;

  localparam int CW = 16;
  localparam int D  = 4;

  logic clk;
  logic reset;
  int   vectors     = 0;
  int   miscompares = 0;
  bit   cmpOn       = 1'b0;

  // Model: phase 0=idle,1=run,2=fire; mN = enabled cycles into current interval.
  int   mPhase;
  int   mN;
  int   mP;
  logic mMode;
  logic mOver;

  tick_sequencer_if #(.CW(CW)) bus();

  tick_sequencer #(
    .CW       (CW),
    .PRESCALE (D)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // An interval of P ticks elapses after P*D enabled cycles; remaining ticks
  // are derived from elapsed time rather than tracked as a counter.
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      mPhase <= 0;
      mN     <= 0;
      mP     <= 0;
      mMode  <= 1'b0;
      mOver  <= 1'b0;
    end else begin
      mOver <= 1'b0;
      if (bus.stop) begin
        mPhase <= 0;
        mN     <= 0;
      end else if (bus.start && bus.period != '0) begin
        mOver  <= (mPhase != 0);
        mPhase <= 1;
        mN     <= 0;
        mP     <= int'(bus.period);
        mMode  <= bus.mode;
      end else if (mPhase == 1 && bus.en) begin
        if (mN + 1 == mP * D) begin
          mPhase <= 2;
          mN     <= 0;
        end else begin
          mN <= mN + 1;
        end
      end else if (mPhase == 2) begin
        mPhase <= (mMode == MODE_PERIODIC) ? 1 : 0;
        mN     <= (mMode == MODE_PERIODIC && bus.en) ? 1 : 0;
      end
    end
  end

  task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input logic e, input logic s, input logic st,
                               input logic m, input logic [CW-1:0] p);
    bus.en     = e;
    bus.start  = s;
    bus.stop   = st;
    bus.mode   = m;
    bus.period = p;
  endtask

  always @(negedge clk) begin
    if (cmpOn) begin
      checkOutput("model rdy", 16'(bus.rdy), 16'(mPhase == 2));
      checkOutput("model busy", 16'(bus.busy), 16'(mPhase != 0));
      checkOutput("model count", bus.count, (mPhase == 1) ? 16'(mP - mN / D) : 16'(0));
      checkOutput("model overrun", 16'(bus.overrun), 16'(mOver));
    end
  end

  initial begin
    reset = 1'b1;
    applyStimulus(1'b1, 1'b0, 1'b0, MODE_ONESHOT, '0);
    #1 reset = 1'b0;
    cmpOn = 1'b1;
    #2;
    checkOutput("reset rdy", 16'(bus.rdy), 16'(0));
    checkOutput("reset busy", 16'(bus.busy), 16'(0));
    checkOutput("reset count", bus.count, 16'(0));
    checkOutput("reset overrun", 16'(bus.overrun), 16'(0));
    repeat (2) @(negedge clk);
    reset = 1'b1;

    $display("[TB] one-shot period 3");
    @(negedge clk);
    applyStimulus(1'b1, 1'b1, 1'b0, MODE_ONESHOT, 16'd3);
    for (int c = 1; c <= 14; c++) begin
      @(negedge clk);
      if (c == 1) applyStimulus(1'b1, 1'b0, 1'b0, MODE_ONESHOT, '0);
      checkOutput("oneshot rdy", 16'(bus.rdy), 16'(c == 13));
      checkOutput("oneshot busy", 16'(bus.busy), 16'(c <= 13));
      if (c % 4 == 1) checkOutput("oneshot count", bus.count, 16'(3 - (c - 1) / 4));
    end

    $display("[TB] periodic period 2, stop in FIRE");
    @(negedge clk);
    applyStimulus(1'b1, 1'b1, 1'b0, MODE_PERIODIC, 16'd2);
    for (int c = 1; c <= 30; c++) begin
      @(negedge clk);
      if (c == 1)  applyStimulus(1'b1, 1'b0, 1'b0, MODE_PERIODIC, '0);
      if (c == 17) applyStimulus(1'b1, 1'b0, 1'b1, MODE_PERIODIC, '0);
      if (c == 18) applyStimulus(1'b1, 1'b0, 1'b0, MODE_PERIODIC, '0);
      checkOutput("periodic rdy", 16'(bus.rdy), 16'(c == 9 || c == 17));
      if (c >= 18) checkOutput("periodic stopped busy", 16'(bus.busy), 16'(0));
    end

    $display("[TB] restart period 5 -> 2");
    @(negedge clk);
    applyStimulus(1'b1, 1'b1, 1'b0, MODE_ONESHOT, 16'd5);
    for (int c = 1; c <= 25; c++) begin
      @(negedge clk);
      if (c == 1) applyStimulus(1'b1, 1'b0, 1'b0, MODE_ONESHOT, '0);
      if (c == 7) applyStimulus(1'b1, 1'b1, 1'b0, MODE_ONESHOT, 16'd2);
      if (c == 8) applyStimulus(1'b1, 1'b0, 1'b0, MODE_ONESHOT, '0);
      checkOutput("restart overrun", 16'(bus.overrun), 16'(c == 8));
      checkOutput("restart rdy", 16'(bus.rdy), 16'(c == 16));
      if (c == 8) checkOutput("restart count", bus.count, 16'(2));
    end

    $display("[TB] pause with en low for 3 cycles");
    @(negedge clk);
    applyStimulus(1'b1, 1'b1, 1'b0, MODE_ONESHOT, 16'd1);
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      if (c == 1) applyStimulus(1'b1, 1'b0, 1'b0, MODE_ONESHOT, '0);
      if (c == 2) applyStimulus(1'b0, 1'b0, 1'b0, MODE_ONESHOT, '0);
      if (c == 5) applyStimulus(1'b1, 1'b0, 1'b0, MODE_ONESHOT, '0);
      checkOutput("pause rdy", 16'(bus.rdy), 16'(c == 8));
    end

    $display("[TB] zero period in IDLE");
    @(negedge clk);
    applyStimulus(1'b1, 1'b1, 1'b0, MODE_PERIODIC, 16'd0);
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      if (c == 1) applyStimulus(1'b1, 1'b0, 1'b0, MODE_ONESHOT, '0);
      checkOutput("zero busy", 16'(bus.busy), 16'(0));
      checkOutput("zero overrun", 16'(bus.overrun), 16'(0));
    end

    $display("[TB] simultaneous start and stop in RUN");
    @(negedge clk);
    applyStimulus(1'b1, 1'b1, 1'b0, MODE_ONESHOT, 16'd5);
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      if (c == 1) applyStimulus(1'b1, 1'b0, 1'b0, MODE_ONESHOT, '0);
      if (c == 3) applyStimulus(1'b1, 1'b1, 1'b1, MODE_ONESHOT, 16'd2);
      if (c == 4) applyStimulus(1'b1, 1'b0, 1'b0, MODE_ONESHOT, '0);
      if (c >= 4) begin
        checkOutput("startstop busy", 16'(bus.busy), 16'(0));
        checkOutput("startstop count", bus.count, 16'(0));
        checkOutput("startstop overrun", 16'(bus.overrun), 16'(0));
      end
    end

    $display("[TB] asynchronous reset mid-RUN");
    @(negedge clk);
    applyStimulus(1'b1, 1'b1, 1'b0, MODE_ONESHOT, 16'd5);
    @(negedge clk);
    applyStimulus(1'b1, 1'b0, 1'b0, MODE_ONESHOT, '0);
    @(negedge clk);
    checkOutput("prereset count", bus.count, 16'(5));
    #2 reset = 1'b0;
    #1;
    checkOutput("async rdy", 16'(bus.rdy), 16'(0));
    checkOutput("async busy", 16'(bus.busy), 16'(0));
    checkOutput("async count", bus.count, 16'(0));
    checkOutput("async overrun", 16'(bus.overrun), 16'(0));
    repeat (2) @(negedge clk);
    reset = 1'b1;
    repeat (30) begin
      @(negedge clk);
      checkOutput("postreset rdy", 16'(bus.rdy), 16'(0));
    end

    $display("[TB] randomized traffic");
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      applyStimulus(logic'($urandom_range(0, 9) != 0),
                    logic'($urandom_range(0, 29) == 0),
                    logic'($urandom_range(0, 59) == 0),
                    logic'($urandom_range(0, 1)),
                    CW'($urandom_range(0, 6)));
    end

    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
